// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Takes the chip-wide synchronized reset and releases NUM_STAGES downstream
//   reset domains one at a time, in order. Stage k+1 is released only after
//   stage k acknowledges (or times out), and then only after STAGE_GAP cycles.
//   A synchronous software/watchdog request restarts the whole sequence.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   sw_rst_req   in   synchronous request to restart the sequence
//   stage_ack    in   [NUM_STAGES] bit k high = domain k out of reset and ready
//   rst_out      out  [NUM_STAGES] active-high reset to each domain, registered
//   seq_busy     out  sequence in progress (complement of seq_done), registered
//   seq_done     out  all stages released and acked/timed out, registered
//   timeout_err  out  sticky flag, some stage hit ACK_TIMEOUT, registered
//
// Build option
//   RESET_SEQ_ACK_TIMEOUT_EN  when defined, a stage that does not ack within
//                             ACK_TIMEOUT cycles of its release is treated as
//                             acked and timeout_err is set. When undefined the
//                             sequencer waits indefinitely and timeout_err is 0.

module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned ACK_TIMEOUT = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  timeout_err
);

  localparam int unsigned K_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  // Saturation point: the largest count any state ever needs to reach.
  localparam int unsigned CNT_SAT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_SAT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
`endif
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_REL_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  seq_done_q, seq_done_d;
  logic                  seq_busy_q;
  logic                  timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0]      cnt_inc;
  logic [NUM_STAGES-1:0] next_mask;
  logic                  ack_hit;

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    rst_out_d     = rst_out_q;
    seq_done_d    = seq_done_q;
    timeout_err_d = timeout_err_q;
    ack_hit       = 1'b0;
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    cnt_d         = cnt_inc;
    // One-hot bit of the stage that follows the current one.
    next_mask     = NUM_STAGES'(1) << (k_q + K_W'(1));

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rst_out_d[0] = 1'b0;
          state_d      = S_REL_WAIT;
          cnt_d        = '0;
          k_d          = '0;
        end
      end

      S_REL_WAIT: begin
        ack_hit = stage_ack[k_q];
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
        // A missing ack at the deadline is treated as an ack on that edge.
        if (!ack_hit && (cnt_q == TO_LAST)) begin
          ack_hit       = 1'b1;
          timeout_err_d = 1'b1;
        end
`endif
        if (ack_hit) begin
          cnt_d = '0;
          if (k_q == K_LAST) begin
            seq_done_d = 1'b1;
            state_d    = S_DONE;
          end else if (STAGE_GAP == 0) begin
            // Zero gap: release the next stage on the ack edge itself.
            rst_out_d = rst_out_q & ~next_mask;
            k_d       = k_q + K_W'(1);
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          rst_out_d = rst_out_q & ~next_mask;
          k_d       = k_q + K_W'(1);
          cnt_d     = '0;
          state_d   = S_REL_WAIT;
        end
      end

      S_DONE: begin
        cnt_d = cnt_q;
      end

      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Restart wins over everything; timeout_err is deliberately left alone.
    if (sw_rst_req) begin
      state_d    = S_HOLD;
      cnt_d      = '0;
      k_d        = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      k_q           <= '0;
      rst_out_q     <= '1;
      seq_done_q    <= 1'b0;
      seq_busy_q    <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      rst_out_q     <= rst_out_d;
      seq_done_q    <= seq_done_d;
      seq_busy_q    <= ~seq_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign seq_done    = seq_done_q;
  assign seq_busy    = seq_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
